// File: rtl/aes_round_key_unit_if.sv
// Bus bundle for aes_round_key_unit: expansion handshake, key input,
// round-key selection/mixing and the 7-segment debug outputs.
interface aes_round_key_unit_if #(
    parameter int NK = 4
);
    logic              start;
    logic [32*NK-1:0]  key_in;
    logic              busy;
    logic              done;
    logic              keys_valid;
    logic [3:0]        rk_idx;
    logic [127:0]      state_in;
    logic [127:0]      round_key;
    logic [127:0]      state_out;
    logic [6:0]        hex0;
    logic [6:0]        hex1;
    logic [6:0]        hex2;

    modport master (
        output start, key_in, rk_idx, state_in,
        input  busy, done, keys_valid, round_key, state_out, hex0, hex1, hex2
    );

    modport slave (
        input  start, key_in, rk_idx, state_in,
        output busy, done, keys_valid, round_key, state_out, hex0, hex1, hex2
    );
endinterface

// File: rtl/aes_round_key_unit.sv
// AES key expansion (one schedule word per clock), round-key storage,
// AddRoundKey mixing of a 128-bit state and 7-segment debug of the result.
module aes_round_key_unit #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_round_key_unit_if.slave bus
);
    localparam int NW = 4 * (NR + 1);

    // Standard AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_load;
    logic         w_write;
    logic         w_last;
    logic [31:0]  r_w [NW];
    logic [5:0]   r_idx;
    logic [2:0]   r_mod;
    logic [7:0]   r_rcon;
    logic         r_done;
    logic         r_keys_valid;
    logic [31:0]  w_prev;
    logic [31:0]  w_temp;
    logic [31:0]  w_new_word;
    logic [5:0]   w_base;
    logic [127:0] w_round_key;
    logic [127:0] w_state_out;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        sub_byte = SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [6:0] seg7_code(input logic [3:0] n);
        case (n)
            4'h0:    seg7_code = 7'h40;
            4'h1:    seg7_code = 7'h79;
            4'h2:    seg7_code = 7'h24;
            4'h3:    seg7_code = 7'h30;
            4'h4:    seg7_code = 7'h19;
            4'h5:    seg7_code = 7'h12;
            4'h6:    seg7_code = 7'h02;
            4'h7:    seg7_code = 7'h78;
            4'h8:    seg7_code = 7'h00;
            4'h9:    seg7_code = 7'h10;
            4'ha:    seg7_code = 7'h08;
            4'hb:    seg7_code = 7'h03;
            4'hc:    seg7_code = 7'h46;
            4'hd:    seg7_code = 7'h21;
            4'he:    seg7_code = 7'h06;
            4'hf:    seg7_code = 7'h0e;
            default: seg7_code = 7'h7f;
        endcase
    endfunction

    assign w_last = (r_idx == 6'(NW - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_EXPAND;
                else           w_state_nxt = ST_IDLE;
            end
            ST_EXPAND: begin
                if (w_last) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_EXPAND;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: key load on an accepted start, one word write per busy cycle.
    always_comb begin
        w_load  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            ST_IDLE:   w_load  = bus.start;
            ST_EXPAND: w_write = 1'b1;
            default: begin
                w_load  = 1'b0;
                w_write = 1'b0;
            end
        endcase
    end

    // Next schedule word; r_mod tracks i mod NK without a divider.
    always_comb begin
        w_prev = r_w[r_idx - 6'd1];
        if (r_mod == 3'd0) begin
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
        end else if ((NK > 6) && (r_mod == 3'd4)) begin
            w_temp = sub_word(w_prev);
        end else begin
            w_temp = w_prev;
        end
        w_new_word = r_w[r_idx - 6'(NK)] ^ w_temp;
    end

    for (genvar g = 0; g < NW; g++) begin : g_word
        if (g < NK) begin : g_key
            // Cipher-key word: loaded straight from key_in on an accepted start.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_w[g] <= 32'h0;
                end else if (w_load) begin
                    r_w[g] <= bus.key_in[32*(NK-g)-1 -: 32];
                end
            end
        end else begin : g_exp
            // Expanded word: written once when the counter reaches its index.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_w[g] <= 32'h0;
                end else if (w_write && (r_idx == 6'(g))) begin
                    r_w[g] <= w_new_word;
                end
            end
        end
    end

    // Word counter, Rcon generator and completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= 6'd0;
            r_mod        <= 3'd0;
            r_rcon       <= 8'h01;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= w_write && w_last;
            if (w_load) begin
                r_idx        <= 6'(NK);
                r_mod        <= 3'd0;
                r_rcon       <= 8'h01;
                r_keys_valid <= 1'b0;
            end else if (w_write) begin
                r_idx <= r_idx + 6'd1;
                r_mod <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
                if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
                if (w_last) r_keys_valid <= 1'b1;
            end
        end
    end

    assign w_base = {bus.rk_idx, 2'b00};

    // Round-key select; out-of-range indices mix in zero.
    always_comb begin
        w_round_key = 128'h0;
        if (bus.rk_idx <= 4'(NR)) begin
            w_round_key = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
        end else begin
            w_round_key = 128'h0;
        end
    end

    assign w_state_out    = bus.state_in ^ w_round_key;
    assign bus.round_key  = w_round_key;
    assign bus.state_out  = w_state_out;
    assign bus.hex0       = seg7_code(w_state_out[127:124]);
    assign bus.hex1       = seg7_code(w_state_out[123:120]);
    assign bus.hex2       = seg7_code(w_state_out[119:116]);
    assign bus.busy       = (r_state == ST_EXPAND);
    assign bus.done       = r_done;
    assign bus.keys_valid = r_keys_valid;
endmodule

// File: tb/tb_aes_round_key_unit.sv
// Directed bench for aes_round_key_unit with AES-128 and AES-256 instances
// against FIPS-197 reference round keys.
module tb_aes_round_key_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;

    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [255:0] K3      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] S0      = 128'h0123456789abcdeffedcba9876543210;

    logic [6:0] seg_exp [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    always #5 clk = ~clk;

    aes_round_key_unit_if #(.NK(4)) bus4 ();
    aes_round_key_unit_if #(.NK(8)) bus8 ();

    aes_round_key_unit #(.NK(4), .NR(10)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    aes_round_key_unit #(.NK(8), .NR(14)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Start an expansion on one instance and count edges (start edge = 1) until done.
    task automatic expand(input bit wide, input logic [255:0] key, input bit extra_starts, output int cycles);
        @(negedge clk);
        if (wide) begin
            bus8.key_in = key;
            bus8.start  = 1'b1;
        end else begin
            bus4.key_in = key[127:0];
            bus4.start  = 1'b1;
        end
        @(posedge clk);
        cycles = 1;
        #1;
        bus4.start = 1'b0;
        bus8.start = 1'b0;
        check_eq("busy_after_start", wide ? bus8.busy : bus4.busy, 128'd1);
        check_eq("kv_clear_after_start", wide ? bus8.keys_valid : bus4.keys_valid, 128'd0);
        while ((wide ? bus8.done : bus4.done) !== 1'b1 && cycles < 200) begin
            if (extra_starts && (cycles % 7 == 3)) begin
                bus4.start  = 1'b1;
                bus4.key_in = ~key[127:0];
            end else begin
                bus4.start  = 1'b0;
            end
            @(posedge clk);
            cycles++;
            #1;
        end
        bus4.start  = 1'b0;
        bus4.key_in = key[127:0];
        check_eq("busy_low_at_done", wide ? bus8.busy : bus4.busy, 128'd0);
        check_eq("kv_high_at_done", wide ? bus8.keys_valid : bus4.keys_valid, 128'd1);
        @(posedge clk);
        #1;
        check_eq("done_single_pulse", wide ? bus8.done : bus4.done, 128'd0);
    endtask

    initial begin
        bus4.start = 1'b0; bus4.key_in = '0; bus4.rk_idx = 4'd0; bus4.state_in = S0;
        bus8.start = 1'b0; bus8.key_in = '0; bus8.rk_idx = 4'd0; bus8.state_in = S0;
        #2;
        check_eq("rst_busy", bus4.busy, 128'd0);
        check_eq("rst_done", bus4.done, 128'd0);
        check_eq("rst_kv", bus4.keys_valid, 128'd0);
        check_eq("rst_round_key", bus4.round_key, 128'h0);
        check_eq("rst_state_out", bus4.state_out, S0);
        check_eq("rst_kv_256", bus8.keys_valid, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 appendix A.1 key.
        expand(1'b0, {128'h0, K1}, 1'b0, cyc);
        check_eq("aes128_done_latency", 128'(cyc), 128'd41);
        bus4.rk_idx = 4'd10; #1;
        check_eq("k1_rk10", bus4.round_key, K1_RK10);
        bus4.rk_idx = 4'd1; #1;
        check_eq("k1_rk1", bus4.round_key, K1_RK1);
        bus4.rk_idx = 4'd0; #1;
        check_eq("k1_rk0", bus4.round_key, K1);

        // Restart from a valid schedule with the appendix C.1 key.
        expand(1'b0, {128'h0, K2}, 1'b0, cyc);
        check_eq("restart_latency", 128'(cyc), 128'd41);
        bus4.rk_idx = 4'd0;
        bus4.state_in = 128'h00112233445566778899aabbccddeeff; #1;
        check_eq("k2_state_out_rk0", bus4.state_out, 128'h00102030405060708090a0b0c0d0e0f0);
        check_eq("k2_hex0", bus4.hex0, 128'h40);
        check_eq("k2_hex1", bus4.hex1, 128'h40);
        check_eq("k2_hex2", bus4.hex2, 128'h79);
        bus4.rk_idx = 4'd10; #1;
        check_eq("k2_rk10", bus4.round_key, K2_RK10);

        // Out-of-range index passes the state through; sweep the hex0 decoder.
        bus4.rk_idx = 4'd15;
        bus4.state_in = 128'hdeadbeef0badf00dcafebabe12345678; #1;
        check_eq("rk15_round_key", bus4.round_key, 128'h0);
        check_eq("rk15_passthru", bus4.state_out, 128'hdeadbeef0badf00dcafebabe12345678);
        for (int n = 0; n < 16; n++) begin
            bus4.state_in = {4'(n), 124'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5};
            #1;
            check_eq($sformatf("hex0_nibble_%0h", n), bus4.hex0, 128'(seg_exp[n]));
        end

        // AES-256, appendix C.3 key.
        expand(1'b1, K3, 1'b0, cyc);
        check_eq("aes256_done_latency", 128'(cyc), 128'd53);
        bus8.rk_idx = 4'd14; #1;
        check_eq("k3_rk14", bus8.round_key, K3_RK14);
        bus8.rk_idx = 4'd0; #1;
        check_eq("k3_rk0", bus8.round_key, K3[255:128]);
        bus8.rk_idx = 4'd15; #1;
        check_eq("k3_rk15", bus8.round_key, 128'h0);

        // Extra starts while busy, then an asynchronous reset mid-expansion.
        @(negedge clk);
        bus4.key_in = K1; bus4.start = 1'b1; bus4.rk_idx = 4'd1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus4.start  = k[0];
            bus4.key_in = ~K1;
        end
        #1;
        check_eq("busy_despite_starts", bus4.busy, 128'd1);
        @(negedge clk);
        bus4.start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", bus4.busy, 128'd0);
        check_eq("midrst_kv", bus4.keys_valid, 128'd0);
        check_eq("midrst_round_key", bus4.round_key, 128'h0);
        check_eq("midrst_kv_256", bus8.keys_valid, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        expand(1'b0, {128'h0, K1}, 1'b1, cyc);
        check_eq("post_rst_latency", 128'(cyc), 128'd41);
        bus4.rk_idx = 4'd10; #1;
        check_eq("post_rst_rk10", bus4.round_key, K1_RK10);
        bus4.rk_idx = 4'd1; #1;
        check_eq("post_rst_rk1", bus4.round_key, K1_RK1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
